mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory controller of the 8-bit pipelined MIPS core; sits between EX_MEM outputs and MEM_WB inputs.
- Turns the stage's MemRead/MemWrite into a req/ack transaction on a variable-latency data-memory port.
- Stalls the pipeline until the access completes, then presents MemoryReadData to MEM_WB.
- Bounded wait: a timeout releases the pipeline and sets a sticky error flag.

Parameters:
- DATA_W, 8, data width.
- ADDR_W, 8, address width.
- TIMEOUT, 15, maximum WAIT cycles before abort; 0 disables the timeout.
- CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load in MEM stage (from EX_MEM).
- MemWrite  in  1  store in MEM stage (from EX_MEM).
- AluOut  in  ADDR_W  effective address.
- WriteData  in  DATA_W  store data.
- Stall  out  1  holds PC/IF_ID/ID_EX/EX_MEM; MEM_WB receives a bubble while high.
- MemoryReadData  out  DATA_W  load result to MEM_WB; registered.
- mem_req  out  1  memory request; registered.
- mem_we  out  1  1 = write; registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- mem_ack  in  1  transaction complete; single-cycle pulse.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - Synchronous, active-high; clk is the only clock.
  - rst high at a rising edge forces: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MemoryReadData=0, mem_err=0.
  - Stall evaluates 0 while state=IDLE with no access pending.
  - rst during WAIT aborts the transaction: mem_req is low from the next cycle, no data is captured, and any later ack is ignored.
- States: IDLE, WAIT, DONE (encoding in package).
- IDLE:
  - access = MemRead | MemWrite.
  - If access: Stall=1 combinationally. At the edge, latch mem_addr<=AluOut, mem_wdata<=WriteData, mem_we<=MemWrite, mem_req<=1, counter<=0, go WAIT.
  - MemRead and MemWrite both high: treated as a write; MemoryReadData is not updated.
  - No access: Stall=0 and MemoryReadData holds its value.
- WAIT:
  - Stall=1, mem_req=1, and all mem_* outputs stay stable.
  - mem_ack=1: if not mem_we, MemoryReadData<=mem_rdata. Then mem_req<=0 and go DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: mem_req<=0, mem_err<=1, MemoryReadData<=0 if the access was a read, go DONE.
  - Else counter<=counter+1, saturating.
- DONE:
  - Stall=0; the pipeline advances at this edge and the MEM_WB register captures MemoryReadData.
  - Always returns to IDLE; inputs are not sampled in DONE.
  - Back-to-back memory instructions therefore cost 3 cycles each with a zero-wait memory.
- Latency:
  - Access seen in cycle 0; mem_req is high from cycle 1.
  - Ack in cycle k (k>=1) puts the FSM in DONE in cycle k+1, with data valid and Stall low.
  - Stall is high for cycles 0..k.
- mem_ack outside WAIT is ignored.
- mem_err clears only on rst.
- Non-memory instructions pass through with zero added latency.

Decomposition:
- Shared package mips_mem_pkg holds:
  - DATA_W and ADDR_W constants;
  - the state typedef/encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10);
  - the default TIMEOUT.
- One natural sub-module, mem_timeout_counter: clear, enable, terminal-count output, saturating.
- FSM and datapath registers stay in mem_access_stage.

Test Plan:
- Reset mid-WAIT: MemRead with ack withheld, rst asserted in cycle 3 -> mem_req=0, Stall=0, state IDLE in cycle 4; a late ack in cycle 5 changes nothing; MemoryReadData=0.
- Zero-wait load: MemRead=1, AluOut=8'h2A; memory acks in cycle 1 with mem_rdata=8'h5C -> mem_addr=8'h2A and mem_we=0 in cycle 1; Stall high in cycles 0-1 and low in cycle 2; MemoryReadData=8'h5C in cycle 2.
- Store with 4-cycle latency: MemWrite=1, AluOut=8'h10, WriteData=8'hA5, ack in cycle 4 -> mem_we=1 and mem_wdata=8'hA5 stable in cycles 1-4; Stall low in cycle 5; MemoryReadData unchanged.
- Timeout, TIMEOUT=15, read with no ack -> mem_req drops after 15 WAIT cycles; mem_err=1 and stays 1; MemoryReadData=0; Stall low in the following DONE cycle.
- Simultaneous MemRead=MemWrite=1 -> write transaction issued (mem_we=1) and MemoryReadData holds its prior value (e.g. 8'h5C).
- Back-to-back loads at 8'h01 then 8'h02, zero-wait memory -> second mem_req rises exactly 3 cycles after the first; both data values are presented in their own DONE cycles; spurious ack in IDLE is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths, state encoding and default timeout for the MEM stage
package mips_mem_pkg;
  localparam int DATA_W          = 8;
  localparam int ADDR_W          = 8;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - saturating WAIT-cycle counter with terminal-count flag
module mem_timeout_counter #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);
  // TIMEOUT of zero never reaches terminal count, which disables the abort path.
  localparam logic [CNT_W-1:0] TERM = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (TIMEOUT != 0) && (r_count == TERM);
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage req/ack data-memory controller with pipeline stall and timeout
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int DATA_W  = mips_mem_pkg::DATA_W,
  parameter int ADDR_W  = mips_mem_pkg::ADDR_W,
  parameter int TIMEOUT = mips_mem_pkg::TIMEOUT_DEFAULT,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] AluOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic [DATA_W-1:0] MemoryReadData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);
  mem_state_t        r_state;
  mem_state_t        w_next;
  logic              w_access;
  logic              w_timeout;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  assign w_access = MemRead | MemWrite;

  mem_timeout_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == IDLE),
    .i_enable   ((r_state == WAIT) && !mem_ack),
    .o_terminal (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_access) w_next = WAIT;
      WAIT:    if (mem_ack || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    case (r_state)
      IDLE:    Stall = w_access;
      WAIT:    Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  // A request with both strobes high is issued as a store, so MemoryReadData is left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite;
            r_addr  <= AluOut;
            r_wdata <= WriteData;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rdata <= mem_rdata;
          end else if (w_timeout) begin
            r_req <= 1'b0;
            r_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign MemoryReadData = r_rdata;
  assign mem_err        = r_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage (directed plus random transactions)
module tb_mem_access_stage;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] AluOut;
  logic [7:0] WriteData;
  logic       Stall;
  logic [7:0] MemoryReadData;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       mem_err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_rdata;
  logic       exp_err;

  mem_access_stage #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .TIMEOUT (TO),
    .CNT_W   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .AluOut         (AluOut),
    .WriteData      (WriteData),
    .Stall          (Stall),
    .MemoryReadData (MemoryReadData),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One memory instruction as seen by the pipeline: k is the ack cycle, 0 means no ack ever.
  task automatic run_txn(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int k, input logic [7:0] rdata);
    logic acc;
    logic is_read;
    int   last;
    acc       = rd | wr;
    is_read   = rd & ~wr;
    MemRead   = rd;
    MemWrite  = wr;
    AluOut    = addr;
    WriteData = wdata;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 8'($urandom);
    #1;
    chk("stall_c0", Stall, acc);
    chk("req_c0", mem_req, 0);
    chk("rdata_c0", MemoryReadData, exp_rdata);
    if (!acc) begin
      cyc();
      return;
    end
    last = (k == 0) ? TO : k;
    for (int c = 1; c <= last; c++) begin
      cyc();
      mem_ack   = (k != 0) && (c == k);
      mem_rdata = mem_ack ? rdata : 8'($urandom);
      #1;
      chk("req_wait", mem_req, 1);
      chk("we_wait", mem_we, wr);
      chk("addr_wait", mem_addr, addr);
      chk("wdata_wait", mem_wdata, wdata);
      chk("stall_wait", Stall, 1);
      chk("rdata_wait", MemoryReadData, exp_rdata);
    end
    cyc();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 8'($urandom);
    if (k == 0) begin
      exp_err = 1'b1;
      if (is_read) exp_rdata = 8'h00;
    end else if (is_read) begin
      exp_rdata = rdata;
    end
    #1;
    chk("stall_done", Stall, 0);
    chk("req_done", mem_req, 0);
    chk("rdata_done", MemoryReadData, exp_rdata);
    chk("err_done", mem_err, exp_err);
    cyc();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    AluOut    = 8'h00;
    WriteData = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    cyc();
    cyc();
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", MemoryReadData, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_stall", Stall, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic       r_rd;
    logic       r_wr;
    int         r_k;
    int         sel;

    do_reset();

    // Reset mid-WAIT: late ack must be ignored.
    MemRead = 1'b1;
    AluOut  = 8'h33;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    MemRead = 1'b0;
    #1;
    chk("rstw_req", mem_req, 0);
    chk("rstw_stall", Stall, 0);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("rstw_rdata", MemoryReadData, 0);
    chk("rstw_req2", mem_req, 0);
    chk("rstw_stall2", Stall, 0);
    chk("rstw_err", mem_err, 0);
    cyc();

    run_txn(1'b1, 1'b0, 8'h2A, 8'h00, 1, 8'h5C);
    run_txn(1'b0, 1'b1, 8'h10, 8'hA5, 4, 8'h77);
    run_txn(1'b1, 1'b1, 8'h20, 8'h3C, 2, 8'h99);
    chk("both_hold", MemoryReadData, 8'h5C);
    run_txn(1'b1, 1'b0, 8'h01, 8'h00, 1, 8'h11);
    run_txn(1'b1, 1'b0, 8'h02, 8'h00, 1, 8'h22);
    run_txn(1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00);
    run_txn(1'b1, 1'b0, 8'h44, 8'h00, 0, 8'h00);
    chk("to_err_sticky", mem_err, 1);

    for (int i = 0; i < 60; i++) begin
      sel  = int'($urandom_range(0, 9));
      r_rd = 1'($urandom_range(0, 1));
      r_wr = 1'($urandom_range(0, 1));
      if (sel == 0) begin
        r_rd = 1'b0;
        r_wr = 1'b0;
      end
      r_k = (sel == 1) ? 0 : int'($urandom_range(1, 6));
      run_txn(r_rd, r_wr, 8'($urandom), 8'($urandom), r_k, 8'($urandom));
    end

    do_reset();
    chk("final_err_clear", mem_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
